// File: rtl/me_pkg.sv
// Shared constants, FSM state type and pixel helpers for the block-matching
// SAD datapath.
package me_pkg;

  localparam int ROWS   = 47;
  localparam int COLS   = 3;
  localparam int BLK    = 16;
  localparam int PIX_W  = 8;
  localparam int SAD_W  = 12;
  localparam int OFFS   = ROWS - BLK + 1;
  localparam int ADDR_W = 8;
  localparam int OFF_W  = 5;
  localparam int IDX_W  = 4;

  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } me_state_t;

  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/me_sad_accum.sv
// Absolute-difference accumulator for one column SAD, plus the running
// minimum tracker over candidate offsets.
module me_sad_accum
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             data_vld,
  input  logic             data_first,
  input  logic             data_last,
  input  logic [OFF_W-1:0] data_offset,
  input  logic [PIX_W-1:0] search_px,
  input  logic [PIX_W-1:0] cur_px,
  output logic             sad_valid,
  output logic [OFF_W-1:0] sad_offset,
  output logic [SAD_W-1:0] sad_value,
  output logic [OFF_W-1:0] best_offset,
  output logic [SAD_W-1:0] best_sad
);

  logic [SAD_W-1:0] acc_q;
  logic [PIX_W-1:0] diff;
  logic [SAD_W-1:0] acc_sum;

  // First pixel of an offset reloads the accumulator so offsets never mix.
  always_comb begin
    diff    = absdiff(search_px, cur_px);
    acc_sum = data_first ? SAD_W'(diff) : (acc_q + SAD_W'(diff));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sad_valid   <= 1'b0;
      sad_offset  <= '0;
      sad_value   <= '0;
      best_offset <= '0;
      best_sad    <= SAD_MAX;
    end else begin
      sad_valid <= 1'b0;
      if (data_vld) begin
        acc_q <= acc_sum;
      end
      if (data_vld && data_last) begin
        sad_valid  <= 1'b1;
        sad_value  <= acc_sum;
        sad_offset <= data_offset;
        // Strict compare: on a tie the earlier (lower) offset is kept.
        if (acc_sum < best_sad) begin
          best_sad    <= acc_sum;
          best_offset <= data_offset;
        end
      end
      if (init) begin
        best_sad    <= SAD_MAX;
        best_offset <= '0;
      end
    end
  end

endmodule

// File: rtl/me_sad_column_engine.sv
// Column SAD engine: walks every vertical offset of one search-buffer column
// against the current-block column and reports per-offset SADs and the minimum.
module me_sad_column_engine
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        col_sel,
  output logic              busy,
  output logic              done,
  output logic              search_read,
  output logic [ADDR_W-1:0] search_read_addr,
  input  logic [PIX_W-1:0]  search_data_out,
  output logic [IDX_W-1:0]  cur_read_addr,
  input  logic [PIX_W-1:0]  cur_data,
  output logic              sad_valid,
  output logic [OFF_W-1:0]  sad_offset,
  output logic [SAD_W-1:0]  sad_value,
  output logic [OFF_W-1:0]  best_offset,
  output logic [SAD_W-1:0]  best_sad,
  output logic [1:0]        state_dbg
);

  // Protocol: start is a single-cycle request taken only while idle with a
  // legal column; busy stays high until the final SAD, then done pulses once.
  // Both buffers are read with a registered strobe/address and return data on
  // the following cycle; reads are never stalled.

  me_state_t         state_q, state_d;
  logic [ADDR_W-1:0] col_base_q;
  logic [OFF_W-1:0]  o_cnt_q;
  logic [IDX_W-1:0]  k_cnt_q;
  logic              rd_vld_q, rd_first_q, rd_last_q;
  logic [OFF_W-1:0]  rd_off_q;
  logic              done_q;

  logic              accept;
  logic              last_read;
  logic [OFF_W-1:0]  o_nxt;
  logic [IDX_W-1:0]  k_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  always_comb begin
    accept    = start && (state_q == IDLE) && (int'(col_sel) < COLS);
    last_read = (o_cnt_q == OFF_W'(OFFS - 1)) && (k_cnt_q == IDX_W'(BLK - 1));
    k_nxt     = k_cnt_q + 1'b1;
    o_nxt     = (k_cnt_q == IDX_W'(BLK - 1)) ? (o_cnt_q + 1'b1) : o_cnt_q;
    addr_nxt  = col_base_q + ADDR_W'(o_nxt) + ADDR_W'(k_nxt);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_read) state_d = DRAIN;
      DRAIN:   if (rd_vld_q && rd_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
    end
  end

  // Address counters hold the offset/pixel of the read currently presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_base_q       <= '0;
      o_cnt_q          <= '0;
      k_cnt_q          <= '0;
      search_read      <= 1'b0;
      search_read_addr <= '0;
      cur_read_addr    <= '0;
    end else if (accept) begin
      col_base_q       <= ADDR_W'(col_sel) * ADDR_W'(ROWS);
      o_cnt_q          <= '0;
      k_cnt_q          <= '0;
      search_read      <= 1'b1;
      search_read_addr <= ADDR_W'(col_sel) * ADDR_W'(ROWS);
      cur_read_addr    <= '0;
    end else if (state_q == RUN) begin
      if (last_read) begin
        search_read <= 1'b0;
      end else begin
        o_cnt_q          <= o_nxt;
        k_cnt_q          <= k_nxt;
        search_read_addr <= addr_nxt;
        cur_read_addr    <= k_nxt;
      end
    end
  end

  // Tags travel one cycle behind the read so they line up with returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_off_q   <= '0;
    end else begin
      rd_vld_q   <= search_read;
      rd_first_q <= (cur_read_addr == '0);
      rd_last_q  <= (cur_read_addr == IDX_W'(BLK - 1));
      rd_off_q   <= o_cnt_q;
    end
  end

  me_sad_accum u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .init        (accept),
    .data_vld    (rd_vld_q),
    .data_first  (rd_first_q),
    .data_last   (rd_last_q),
    .data_offset (rd_off_q),
    .search_px   (search_data_out),
    .cur_px      (cur_data),
    .sad_valid   (sad_valid),
    .sad_offset  (sad_offset),
    .sad_value   (sad_value),
    .best_offset (best_offset),
    .best_sad    (best_sad)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_me_sad_column_engine.sv
// Directed bench for me_sad_column_engine: buffer models, scoreboard of
// expected per-offset SADs, and cycle-exact control/address checks.
module tb_me_sad_column_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  col_sel = 2'd0;
  logic        busy, done, search_read, sad_valid;
  logic [7:0]  search_read_addr;
  logic [7:0]  search_data_out = 8'd0;
  logic [3:0]  cur_read_addr;
  logic [7:0]  cur_data = 8'd0;
  logic [4:0]  sad_offset, best_offset;
  logic [11:0] sad_value, best_sad;
  logic [1:0]  state_dbg;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  logic [7:0]  smem[141];
  logic [7:0]  cmem[16];

  me_sad_column_engine dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .col_sel          (col_sel),
    .busy             (busy),
    .done             (done),
    .search_read      (search_read),
    .search_read_addr (search_read_addr),
    .search_data_out  (search_data_out),
    .cur_read_addr    (cur_read_addr),
    .cur_data         (cur_data),
    .sad_valid        (sad_valid),
    .sad_offset       (sad_offset),
    .sad_value        (sad_value),
    .best_offset      (best_offset),
    .best_sad         (best_sad),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- buffer models ----------------
  always @(posedge clk) begin
    if (search_read && search_read_addr < 8'd141) search_data_out <= smem[search_read_addr];
    cur_data <= cmem[cur_read_addr];
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sad_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sad_unexpected: offset %0d value %0d with nothing expected",
                 sad_offset, sad_value);
      end else begin
        mon_e = exp_q.pop_front();
        check("sad_offset", 32'(sad_offset), 32'(mon_e[16:12]));
        check("sad_value", 32'(sad_value), 32'(mon_e[11:0]));
      end
    end
  end

  task automatic push_exp(input int o, input int v);
    exp_q.push_back({5'(o), 12'(v)});
  endtask

  function automatic int model_sad(input int col, input int o);
    int s = 0;
    for (int k = 0; k < 16; k++) begin
      int d = int'(smem[col*47 + o + k]) - int'(cmem[k]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_search_read"}, 32'(search_read), 0);
    check({tag, "_search_addr"}, 32'(search_read_addr), 0);
    check({tag, "_cur_addr"}, 32'(cur_read_addr), 0);
    check({tag, "_sad_valid"}, 32'(sad_valid), 0);
    check({tag, "_sad_offset"}, 32'(sad_offset), 0);
    check({tag, "_sad_value"}, 32'(sad_value), 0);
    check({tag, "_best_offset"}, 32'(best_offset), 0);
    check({tag, "_best_sad"}, 32'(best_sad), 4095);
    check({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  // ---------------- driver ----------------
  // One column pass, checked cycle by cycle. poke_at pulses a stray start with
  // another column; rst_at drops rst_n mid-cycle and ends the pass early.
  task automatic run_pass(input logic [1:0] col, input int poke_at, input int rst_at);
    int         done_cyc = -1;
    int         seq_err = 0;
    int         busy_err = 0;
    int         amin = 255;
    int         amax = 0;
    logic [7:0] base;
    logic [7:0] exp_addr;
    base = 8'(col) * 8'd47;
    @(negedge clk);
    start   = 1'b1;
    col_sel = col;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 520; c++) begin
      if (c == poke_at) begin
        start   = 1'b1;
        col_sel = (col == 2'd0) ? 2'd2 : 2'd0;
      end else begin
        start = 1'b0;
      end
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midpass_reset");
        check("popped_before_reset", exp_q.size(), 17);
        return;
      end
      if (busy !== ((c <= 513) ? 1'b1 : 1'b0)) busy_err++;
      if (c < 512) begin
        exp_addr = base + 8'(c / 16) + 8'(c % 16);
        if (search_read !== 1'b1 || search_read_addr !== exp_addr ||
            cur_read_addr !== 4'(c % 16)) seq_err++;
        if (int'(search_read_addr) < amin) amin = int'(search_read_addr);
        if (int'(search_read_addr) > amax) amax = int'(search_read_addr);
      end else if (search_read !== 1'b0) begin
        seq_err++;
      end
      if (done === 1'b1) begin
        if (done_cyc < 0) done_cyc = c;
        else seq_err++;
      end
      @(negedge clk);
    end
    check("done_cycle", done_cyc, 514);
    check("busy_window", busy_err, 0);
    check("read_sequence", seq_err, 0);
    check("addr_min", amin, 32'(base));
    check("addr_max", amax, 32'(base) + 46);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic idle_watch(input int cycles, output int busy_seen, output int done_seen);
    busy_seen = 0;
    done_seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
      if (done !== 1'b0) done_seen++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bs, ds;
    for (int i = 0; i < 141; i++) smem[i] = 8'd0;
    for (int k = 0; k < 16; k++) cmem[k] = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);

    // All zero, column 0: every SAD 0, first offset wins the tie.
    for (int o = 0; o < 32; o++) push_exp(o, 0);
    run_pass(2'd0, -1, -1);
    check("zero_best_sad", 32'(best_sad), 0);
    check("zero_best_offset", 32'(best_offset), 0);

    // Column 1 ramp vs cur 7+k: SAD 16*|o-7|; stray start at cycle 100.
    for (int r = 0; r < 47; r++) smem[47 + r] = 8'(r);
    for (int k = 0; k < 16; k++) cmem[k] = 8'(7 + k);
    for (int o = 0; o < 32; o++) push_exp(o, 16 * ((o > 7) ? (o - 7) : (7 - o)));
    run_pass(2'd1, 100, -1);
    check("ramp_best_sad", 32'(best_sad), 0);
    check("ramp_best_offset", 32'(best_offset), 7);

    // Tie: column 0 holds the cur pattern at rows 3 and 20, each off by 50.
    for (int i = 0; i < 141; i++) smem[i] = 8'd0;
    for (int k = 0; k < 16; k++) begin
      cmem[k]       = 8'(16 * k);
      smem[3 + k]   = 8'(16 * k);
      smem[20 + k]  = 8'(16 * k);
    end
    smem[3]  = 8'd50;
    smem[20] = 8'd50;
    for (int o = 0; o < 32; o++) push_exp(o, model_sad(0, o));
    run_pass(2'd0, -1, -1);
    check("tie_best_sad", 32'(best_sad), 50);
    check("tie_best_offset", 32'(best_offset), 3);

    // Saturating column 2: 16*255 per offset, addresses 94..140.
    for (int i = 0; i < 141; i++) smem[i] = 8'd255;
    for (int k = 0; k < 16; k++) cmem[k] = 8'd0;
    for (int o = 0; o < 32; o++) push_exp(o, 4080);
    run_pass(2'd2, -1, -1);
    check("max_best_sad", 32'(best_sad), 4080);
    check("max_best_offset", 32'(best_offset), 0);

    // Illegal column request in idle.
    @(negedge clk);
    start   = 1'b1;
    col_sel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    idle_watch(20, bs, ds);
    check("col3_busy_seen", bs, 0);
    check("col3_done_seen", ds, 0);

    // Reset in the middle of a ramp pass, then a clean full pass.
    for (int i = 0; i < 141; i++) smem[i] = 8'd0;
    for (int r = 0; r < 47; r++) smem[47 + r] = 8'(r);
    for (int k = 0; k < 16; k++) cmem[k] = 8'(7 + k);
    for (int o = 0; o < 32; o++) push_exp(o, 16 * ((o > 7) ? (o - 7) : (7 - o)));
    run_pass(2'd1, -1, 250);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch(600, bs, ds);
    check("post_reset_busy_seen", bs, 0);
    check("post_reset_done_seen", ds, 0);
    for (int o = 0; o < 32; o++) push_exp(o, 16 * ((o > 7) ? (o - 7) : (7 - o)));
    run_pass(2'd1, -1, -1);
    check("rerun_best_sad", 32'(best_sad), 0);
    check("rerun_best_offset", 32'(best_offset), 7);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
